// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter between instruction fetch and load/store.
// Multi-byte accesses run one byte per cycle; reads assemble little-endian words.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [1:0] {StIdle, StIfRd, StMemRd, StMemWr} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [2:0]        n;
    logic [2:0]        req_n;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q;
    logic [31:0]       asm_next;

    assign stall_if  = if_req & ~if_done;
    assign stall_mem = mem_req & ~mem_done;

    always_comb begin
        unique case (mem_size)
            2'b00:   req_n = 3'd1;
            2'b01:   req_n = 3'd2;
            default: req_n = 3'd4;
        endcase
    end

    // ram_din carries the byte addressed in the previous cycle, i.e. byte cnt-1.
    always_comb begin
        asm_next = asm_q;
        case (cnt)
            3'd1:    asm_next[7:0]   = ram_din;
            3'd2:    asm_next[15:8]  = ram_din;
            3'd3:    asm_next[23:16] = ram_din;
            3'd4:    asm_next[31:24] = ram_din;
            default: ;
        endcase
    end

    always_comb begin
        ram_a    = '0;
        ram_wr   = 1'b0;
        ram_dout = 8'h00;
        if (state != StIdle) begin
            ram_a = base + ADDR_W'(cnt);
        end
        if (state == StMemWr) begin
            ram_wr = rdy;
            case (cnt[1:0])
                2'd0:    ram_dout = wdata_q[7:0];
                2'd1:    ram_dout = wdata_q[15:8];
                2'd2:    ram_dout = wdata_q[23:16];
                default: ram_dout = wdata_q[31:24];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= 3'd0;
            n         <= 3'd0;
            base      <= '0;
            wdata_q   <= 32'h0;
            asm_q     <= 32'h0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_inst   <= 32'h0;
            mem_rdata <= 32'h0;
        end else if (rdy) begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                StIdle: begin
                    // No accept while a done pulse is still being presented.
                    if (!if_done && !mem_done) begin
                        if (mem_req) begin
                            state   <= mem_we ? StMemWr : StMemRd;
                            base    <= mem_addr;
                            n       <= req_n;
                            wdata_q <= mem_wdata;
                            cnt     <= 3'd0;
                            asm_q   <= 32'h0;
                        end else if (if_req && !if_cancel) begin
                            state <= StIfRd;
                            base  <= if_addr;
                            n     <= 3'd4;
                            cnt   <= 3'd0;
                            asm_q <= 32'h0;
                        end
                    end
                end
                StMemWr: begin
                    if (cnt == n - 3'd1) begin
                        state    <= StIdle;
                        cnt      <= 3'd0;
                        mem_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                StMemRd, StIfRd: begin
                    if (state == StIfRd && if_cancel) begin
                        state <= StIdle;
                        cnt   <= 3'd0;
                    end else begin
                        if (cnt != 3'd0) begin
                            asm_q <= asm_next;
                        end
                        if (cnt == n) begin
                            state <= StIdle;
                            cnt   <= 3'd0;
                            if (state == StIfRd) begin
                                if_inst <= asm_next;
                                if_done <= 1'b1;
                            end else begin
                                mem_rdata <= asm_next;
                                mem_done  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a byte RAM model, a word-level reference memory,
// directed scenarios followed by randomized traffic with and without rdy stalls.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy = 1'b1;
    logic        if_req, if_cancel, if_done;
    logic [31:0] if_addr, if_inst;
    logic        mem_req, mem_we, mem_done;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'h00;
    logic        stall_if, stall_mem;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .if_done(if_done), .if_inst(if_inst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int hold_lo = -100;
    bit rand_rdy = 1'b0;

    // rdy: either random, or low for the three cycles starting at hold_lo.
    always @(posedge clk) begin
        #1;
        if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
        else rdy = !(cyc >= hold_lo && cyc < hold_lo + 3);
    end

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h100:                   return 8'h13;
            32'h101, 32'h102, 32'h103: return 8'h00;
            32'h10:                    return 8'h34;
            32'h11:                    return 8'h12;
            default:                   return a[7:0] ^ a[15:8] ^ 8'h5a;
        endcase
    endfunction

    // External RAM: 64 KiB window; the test's address set never aliases in it.
    logic [7:0] ram_mem [65536];
    bit         ram_vld [65536];
    always @(posedge clk) begin
        if (rdy) begin
            ram_din <= ram_vld[ram_a[15:0]] ? ram_mem[ram_a[15:0]] : init_byte(ram_a);
            if (ram_wr) begin
                ram_mem[ram_a[15:0]] <= ram_dout;
                ram_vld[ram_a[15:0]] <= 1'b1;
            end
        end
    end

    // Reference memory, full 32-bit byte addressing.
    logic [7:0] shadow [logic [31:0]];
    function automatic logic [7:0] sh_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : init_byte(a);
    endfunction

    typedef struct {
        logic [31:0] data;
        bit          chk;
        int          due;
    } exp_t;
    typedef struct {
        int          due;
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
    } bus_t;
    exp_t mem_q[$];
    exp_t if_q[$];
    bus_t bus_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic issue_mem(input bit we, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wd, input int c0, input bit timed,
                             output int done_at);
        int          n;
        exp_t        e;
        bus_t        b;
        logic [31:0] a;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        done_at = c0 + (we ? n + 1 : n + 2);
        e.data = 32'h0;
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            b.due = c0 + 1 + k;
            b.a = a;
            b.wr = we;
            b.d = wd[8*k +: 8];
            if (timed) bus_q.push_back(b);
            if (we) shadow[a] = wd[8*k +: 8];
            else e.data[8*k +: 8] = sh_rd(a);
        end
        e.chk = !we;
        e.due = timed ? done_at : -1;
        mem_q.push_back(e);
    endtask

    task automatic issue_if(input logic [31:0] addr, input int c0, input bit timed,
                            input int extra, output int done_at);
        exp_t e;
        bus_t b;
        done_at = c0 + 6 + extra;
        for (int k = 0; k < 4; k++) begin
            e.data[8*k +: 8] = sh_rd(addr + 32'(k));
            b.due = c0 + 1 + k;
            b.a = addr + 32'(k);
            b.wr = 1'b0;
            b.d = 8'h00;
            if (timed && extra == 0) bus_q.push_back(b);
        end
        e.chk = 1'b1;
        e.due = timed ? done_at : -1;
        if_q.push_back(e);
    endtask

    task automatic wait_done(input bit is_if);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rdy && (is_if ? if_done : mem_done)) break;
        end
        if (k == 300) begin
            total++;
            bad++;
            $display("FAIL %s timeout: got no done in 300 cycles, want done",
                     is_if ? "if_done" : "mem_done");
        end
        if (is_if) if_req = 1'b0;
        else mem_req = 1'b0;
    endtask

    task automatic run_mem(input bit we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, input bit timed);
        int d;
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wd;
        issue_mem(we, size, addr, wd, cyc, timed, d);
        wait_done(1'b0);
    endtask

    task automatic run_if(input logic [31:0] addr, input bit timed, input int hold_off);
        int d;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = addr;
        if (hold_off > 0) hold_lo = cyc + hold_off;
        issue_if(addr, cyc, timed, (hold_off > 0) ? 3 : 0, d);
        wait_done(1'b1);
        hold_lo = -100;
    endtask

    task automatic run_both(input bit we, input logic [1:0] size, input logic [31:0] maddr,
                            input logic [31:0] wd, input logic [31:0] iaddr, input bit timed);
        int d, d2;
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = maddr; mem_wdata = wd;
        if_req = 1'b1; if_addr = iaddr;
        issue_mem(we, size, maddr, wd, cyc, timed, d);
        issue_if(iaddr, d + 1, timed, 0, d2);
        fork
            wait_done(1'b0);
            wait_done(1'b1);
        join
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 4) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        return 32'h800 + 32'($urandom_range(0, 15));
    endfunction

    task automatic monitor();
        exp_t e;
        bus_t b;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("stall_if", 32'(stall_if), 32'(if_req & ~if_done));
                chk("stall_mem", 32'(stall_mem), 32'(mem_req & ~mem_done));
                if (!rdy) chk("ram_wr while rdy low", 32'(ram_wr), 32'h0);
                if (rdy && mem_done) begin
                    if (mem_q.size() == 0) chk("unexpected mem_done", 32'(mem_done), 32'h0);
                    else begin
                        e = mem_q.pop_front();
                        if (e.chk) chk("mem_rdata", mem_rdata, e.data);
                        if (e.due >= 0) chk("mem_done cycle", 32'(cyc), 32'(e.due));
                    end
                end
                if (rdy && if_done) begin
                    if (if_q.size() == 0) chk("unexpected if_done", 32'(if_done), 32'h0);
                    else begin
                        e = if_q.pop_front();
                        chk("if_inst", if_inst, e.data);
                        if (e.due >= 0) chk("if_done cycle", 32'(cyc), 32'(e.due));
                    end
                end
                while (bus_q.size() != 0 && bus_q[0].due <= cyc) begin
                    b = bus_q.pop_front();
                    chk("ram bus cycle", 32'(cyc), 32'(b.due));
                    chk("ram_a", ram_a, b.a);
                    chk("ram_wr", 32'(ram_wr), 32'(b.wr));
                    if (b.wr) chk("ram_dout", 32'(ram_dout), 32'(b.d));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0; if_cancel = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0;
        fork
            monitor();
            begin
                #500000;
                $display("FAIL watchdog: got no end by time limit, want finish");
                $fatal(1, "watchdog");
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                chk("reset if_done", 32'(if_done), 32'h0);
                chk("reset mem_done", 32'(mem_done), 32'h0);
                chk("reset if_inst", if_inst, 32'h0);
                chk("reset mem_rdata", mem_rdata, 32'h0);
                chk("reset ram_a", ram_a, 32'h0);
                chk("reset ram_wr", 32'(ram_wr), 32'h0);
                chk("reset ram_dout", 32'(ram_dout), 32'h0);
                rst = 1'b0;

                run_if(32'h100, 1'b1, 0);
                chk("plan fetch 0x100", if_inst, 32'h0000_0013);
                run_mem(1'b1, 2'b10, 32'h2000, 32'hDEAD_BEEF, 1'b1);
                run_mem(1'b0, 2'b00, 32'h2001, 32'h0, 1'b1);
                chk("plan byte load 0x2001", mem_rdata, 32'h0000_00BE);
                run_both(1'b0, 2'b01, 32'h10, 32'h0, 32'h100, 1'b1);
                chk("plan half load 0x10", mem_rdata, 32'h0000_1234);

                // Cancel in cycle 2 of a fetch; keep if_req up so cycle 3 tests accept blocking.
                @(posedge clk); #1;
                if_req = 1'b1; if_addr = 32'h200;
                @(posedge clk); #1;
                @(posedge clk); #1;
                if_cancel = 1'b1;
                @(posedge clk); #1;
                @(negedge clk);
                chk("cancel idle ram_a", ram_a, 32'h0);
                @(posedge clk); #1;
                if_cancel = 1'b0; if_req = 1'b0;
                @(negedge clk);
                chk("cancel blocks accept ram_a", ram_a, 32'h0);
                repeat (6) @(posedge clk);
                run_if(32'h200, 1'b1, 0);

                run_mem(1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0, 1'b1);
                run_if(32'h100, 1'b1, 2);
                chk("held fetch 0x100", if_inst, 32'h0000_0013);

                // Reset during the second byte of a word store: only byte 0 lands.
                @(posedge clk); #1;
                mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10;
                mem_addr = 32'h3000; mem_wdata = 32'hCAFE_F00D;
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst = 1'b1;
                #1;
                chk("midreset ram_a", ram_a, 32'h0);
                chk("midreset ram_wr", 32'(ram_wr), 32'h0);
                chk("midreset ram_dout", 32'(ram_dout), 32'h0);
                chk("midreset mem_done", 32'(mem_done), 32'h0);
                chk("midreset if_inst", if_inst, 32'h0);
                chk("midreset mem_rdata", mem_rdata, 32'h0);
                mem_req = 1'b0;
                #1;
                rst = 1'b0;
                shadow[32'h3000] = 8'h0D;
                run_mem(1'b0, 2'b10, 32'h3000, 32'h0, 1'b1);

                for (int ph = 0; ph < 2; ph++) begin
                    rand_rdy = (ph == 1);
                    for (int i = 0; i < 30; i++) begin
                        case ($urandom_range(0, 3))
                            0: run_mem(1'b0, 2'($urandom_range(0, 3)), rand_addr(), 32'h0, !rand_rdy);
                            1: run_mem(1'b1, 2'($urandom_range(0, 3)), rand_addr(), $urandom, !rand_rdy);
                            2: run_if(rand_addr(), !rand_rdy, 0);
                            default: run_both(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                                              rand_addr(), $urandom, rand_addr(), !rand_rdy);
                        endcase
                    end
                end
                rand_rdy = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                chk("mem queue drained", 32'(mem_q.size()), 32'h0);
                chk("if queue drained", 32'(if_q.size()), 32'h0);
                chk("bus queue drained", 32'(bus_q.size()), 32'h0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        join_any
    end

endmodule
